// File: rtl/mult_datapath.sv
// Datapath for the 8x8 shift-add multiplier: partial-product register, step counter, product capture.
// Define SIGNED_MULT_EN for two's-complement operands (subtract on the final step, arithmetic shift).
module mult_datapath (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  input  logic        RESET,
  input  logic        ADD,
  input  logic        SHIFT,
  input  logic        DECREMENT,
  input  logic        READY,
  output logic [16:0] register,
  output logic [3:0]  count,
  output logic [15:0] product,
  output logic        product_valid
);

  logic [16:0] register_d, register_q;
  logic [3:0]  count_d, count_q;
  logic [15:0] product_d, product_q;
  logic        product_valid_d, product_valid_q;
  logic        ready_prev_d, ready_prev_q;
  logic [7:0]  upper;
  logic [8:0]  sum;
  logic        fill;

  always_comb begin
    upper = register_q[15:8];
`ifdef SIGNED_MULT_EN
    // The multiplier sign bit carries weight -2^7, so the step seen at count 0 subtracts.
    if (ADD) begin
      if (count_q == 4'd0) sum = {upper[7], upper} - {multiplicand[7], multiplicand};
      else                 sum = {upper[7], upper} + {multiplicand[7], multiplicand};
    end else begin
      sum = {upper[7], upper};
    end
    fill = sum[8];
`else
    sum  = ADD ? ({1'b0, upper} + {1'b0, multiplicand}) : {1'b0, upper};
    fill = 1'b0;
`endif

    register_d = register_q;
    if (RESET)      register_d = {9'b0, multiplier};
    else if (SHIFT) register_d = {fill, sum, register_q[7:1]};
    else if (ADD)   register_d = {sum[8], sum[7:0], register_q[7:0]};

    count_d = count_q;
    if (RESET)                              count_d = 4'd7;
    else if (DECREMENT && count_q != 4'd0) count_d = count_q - 4'd1;

    ready_prev_d    = READY;
    product_valid_d = READY & ~ready_prev_q;
    product_d       = product_valid_d ? register_q[15:0] : product_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      register_q      <= '0;
      count_q         <= '0;
      product_q       <= '0;
      product_valid_q <= 1'b0;
      ready_prev_q    <= 1'b0;
    end else begin
      register_q      <= register_d;
      count_q         <= count_d;
      product_q       <= product_d;
      product_valid_q <= product_valid_d;
      ready_prev_q    <= ready_prev_d;
    end
  end

  assign register      = register_q;
  assign count         = count_q;
  assign product       = product_q;
  assign product_valid = product_valid_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: stimulus pushes expected products, a negedge monitor pops them on product_valid.
module tb_mult_datapath;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        RESET = 1'b0, ADD = 1'b0, SHIFT = 1'b0, DECREMENT = 1'b0, READY = 1'b0;
  logic [16:0] register;
  logic [3:0]  count;
  logic [15:0] product;
  logic        product_valid;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  mult_datapath dut (
    .clk(clk), .n_reset(n_reset), .multiplicand(multiplicand), .multiplier(multiplier),
    .RESET(RESET), .ADD(ADD), .SHIFT(SHIFT), .DECREMENT(DECREMENT), .READY(READY),
    .register(register), .count(count), .product(product), .product_valid(product_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one command cycle; returns 1 time unit after the consuming edge.
  task automatic cmd(input logic r, input logic a, input logic s, input logic d, input logic rdy);
    RESET = r; ADD = a; SHIFT = s; DECREMENT = d; READY = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_step(input logic [7:0] a, input logic [7:0] b, input int unsigned steps);
    multiplicand = a;
    multiplier   = b;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < steps; i++) cmd(1'b0, b[i], 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] req);
    load_and_step(a, b, 8);
    check("count_after_steps", {28'd0, count}, 32'd0);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(req);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (n_reset && product_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse product=%0h required=no_pulse", product);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          bad++;
          $display("FAIL product actual=%0h required=%0h", product, e);
        end
      end
    end
  end

  initial begin
    #3;
    check("rst_register", {15'd0, register}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_valid", {31'd0, product_valid}, 32'd0);
    #10 n_reset = 1'b1;
    @(posedge clk); #1;

    run_mult(8'h0D, 8'h0B, 16'h008F);
`ifdef SIGNED_MULT_EN
    run_mult(8'hFD, 8'h05, 16'hFFF1);
    run_mult(8'h80, 8'h80, 16'h4000);
    run_mult(8'h7F, 8'hFF, 16'hFF81);
    run_mult(8'hFF, 8'hFF, 16'h0001);
`else
    run_mult(8'hFF, 8'hFF, 16'hFE01);
    run_mult(8'h00, 8'hA5, 16'h0000);
    run_mult(8'h01, 8'h80, 16'h0080);
`endif

    // Counter preset and saturation
    multiplier = 8'h3C;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("count_preset", {28'd0, count}, 32'd7);
    check("reset_load", {15'd0, register}, 32'h0003C);
    for (int k = 0; k < 9; k++) begin
      cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("count_dec", {28'd0, count}, (k < 7) ? 32'(6 - k) : 32'd0);
    end

    // Async reset after step 4: everything clears with no capture
    load_and_step(8'h0D, 8'h0B, 4);
    RESET = 1'b0; ADD = 1'b0; SHIFT = 1'b0; DECREMENT = 1'b0; READY = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    check("midrst_register", {15'd0, register}, 32'd0);
    check("midrst_count", {28'd0, count}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    run_mult(8'h0D, 8'h0B, 16'h008F);

    // READY held five cycles: one pulse, product stable
    load_and_step(8'h0D, 8'h0B, 8);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'h008F);
    for (int k = 0; k < 5; k++) begin
      cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("hold_product", {16'd0, product}, 32'h008F);
    end
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    while (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_pulse actual=none required=%0h", exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Datapath for the 8x8 shift-add multiplier, directly downstream of the multiplier sequencer. Holds the 17-bit partial-product/multiplier register and the 4-bit step counter. Executes the sequencer's RESET/ADD/SHIFT/DECREMENT commands, and feeds `register` and `count` back to the sequencer. Latches the finished product when the sequencer raises READY.

## Interface
Parameters: none (operand width fixed at 8, product 16).

Ports:
- `clk`  input  1  rising-edge clock
- `n_reset`  input  1  asynchronous, active-low reset; clock and reset are the only timing inputs (one clock domain)
- `multiplicand`  input  8  operand A, sampled while RESET=1
- `multiplier`  input  8  operand B, sampled while RESET=1
- `RESET`  input  1  load operands, clear accumulator, preset counter
- `ADD`  input  1  add multiplicand into upper partial product this cycle
- `SHIFT`  input  1  shift register right one bit this cycle
- `DECREMENT`  input  1  decrement step counter
- `READY`  input  1  sequencer done flag
- `register`  output  17  {bit16 carry/sign, [15:8] upper partial, [7:0] multiplier remainder}
- `count`  output  4  remaining steps
- `product`  output  16  held result
- `product_valid`  output  1  one-cycle pulse when `product` updates

## Operation
- Reset (`n_reset`=0, async): `register`=0, `count`=0, `product`=0, `product_valid`=0, `ready_d`=0.
- Command priority per clock edge: RESET > (ADD/SHIFT) ; DECREMENT independent of ADD/SHIFT but suppressed by RESET.
- RESET=1: `register` <= {1'b0, 8'h00, multiplier}; `count` <= 4'd7. Repeats every cycle RESET is high; the last RESET cycle's operands are used.
- Let U = `register`[15:8], M = `multiplicand`, s = 9-bit sum.
  - ADD=1: s = {1'b0,U} + {1'b0,M}; ADD=0: s = {1'b0,U}.
  - SHIFT=1: `register` <= {1'b0, s[8:0], `register`[7:1]}.
  - SHIFT=0, ADD=1: `register` <= {s[8], s[7:0], `register`[7:0]} (add without shift).
  - Neither: hold.
- DECREMENT=1: `count` <= `count`-1, saturating at 0 (no wrap to 15).
- Step budget: counter preset 7; sequencer stays in its add/shift state while `count`>0 and issues one more step at 0, giving exactly 8 add/shift steps.
- Product capture: `ready_d` <= READY each cycle. On READY=1 && `ready_d`=0: `product` <= `register`[15:0], `product_valid` <= 1. Otherwise `product_valid` <= 0. `product` holds until the next capture.
- Reset mid-operation: async clear as above; no partial product is captured. RESET command mid-operation reloads cleanly, with no capture.

## Timing
- All state updates on rising `clk`; `register`/`count` are registered outputs, valid 1 cycle after the command cycle.
- Latency: last RESET cycle at edge E0. Add/shift steps occur at E1..E8. Sequencer asserts READY from E9. `product`/`product_valid` are updated at E10.
- `product_valid` is high exactly one cycle per READY rising edge. READY held high for many cycles still gives one pulse.
- ADD and SHIFT in the same cycle are the normal case and complete in one cycle (combinational add feeding the shifter).

## Configuration
- `SIGNED_MULT_EN` defined: two's-complement operands.
  - s = {U[7],U} ± {M[7],M}; subtract when ADD=1 && `count`==0 (multiplier sign-bit step), add otherwise.
  - Shift fills bit16 with s[8] (arithmetic).
  - RESET loads bit16=0, U=0.
- Not defined: unsigned behaviour as in Operation. Bit16 is always 0 after any shift.

## Test plan
- Unsigned 13x11: RESET with A=0x0D, B=0x0B, then 8 ADD=B[0]/SHIFT/DECREMENT steps, READY -> `product`=0x008F, single `product_valid` pulse, `count`=0.
- Unsigned corners: 0xFF x 0xFF -> 0xFE01; 0x00 x 0xA5 -> 0x0000; 0x01 x 0x80 -> 0x0080.
- Counter: RESET -> `count`=7; 9 DECREMENTs -> 6,5,...,0,0 (saturates, never 15).
- Async reset mid-operation: assert `n_reset`=0 after step 4 of 0x0D x 0x0B -> `register`, `count`, `product` all 0 immediately, no `product_valid`. Restart yields 0x008F.
- READY held 5 cycles -> exactly one `product_valid` pulse; `product` stable throughout.
- `SIGNED_MULT_EN`: 0xFD x 0x05 (-3x5) -> 0xFFF1; 0x80 x 0x80 (-128x-128) -> 0x4000; 0x7F x 0xFF (127x-1) -> 0xFF81.
